// File: rtl/cache_pkg.sv
// Shared defaults, FSM encoding and address-split helpers for the set-associative cache storage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

    localparam int CACHE_ADDR_W = 10;
    localparam int CACHE_DATA_W = 32;
    localparam int CACHE_SETS   = 16;
    localparam int CACHE_WAYS   = 2;
    localparam int CACHE_WPL    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Word address layout is {tag, index, offset}, MSB to LSB.
    function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int off_w);
        return addr & ((32'd1 << off_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int off_w,
                                               input int idx_w);
        return (addr >> off_w) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int off_w,
                                             input int idx_w);
        return addr >> (off_w + idx_w);
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Per-set tree pseudo-LRU state: update port marks a way MRU, victim port reads the LRU way.
// Latency: update lands at the next edge; victim read is combinational.
// Backpressure: none; clr wipes every set to the reset state (victim way 0).
//
// Ports: clk, reset (async active-low), clr, upd_en/upd_set/upd_way, vic_set -> vic_way.
// Node bits point at the side holding the victim; WAYS=1 has no storage.
module plru_tree #(
    parameter int SETS = 16,
    parameter int WAYS = 2
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          clr,
    input  logic                                          upd_en,
    input  logic [$clog2(SETS)-1:0]                       upd_set,
    input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]    upd_way,
    input  logic [$clog2(SETS)-1:0]                       vic_set,
    output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]    vic_way
);

    generate
        if (WAYS == 1) begin : g_one
            assign vic_way = '0;
        end else if (WAYS == 2) begin : g_two
            logic [SETS-1:0] bits_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    bits_q <= '0;
                end else if (clr) begin
                    bits_q <= '0;
                end else if (upd_en) begin
                    bits_q[upd_set] <= ~upd_way[0];
                end
            end

            assign vic_way = bits_q[vic_set];
        end else begin : g_four
            // bit0: root (1 = victim in ways 2/3), bit1: ways 0/1, bit2: ways 2/3
            logic [2:0] bits_q [SETS];
            logic [2:0] rd;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    bits_q <= '{default: '0};
                end else if (clr) begin
                    bits_q <= '{default: '0};
                end else if (upd_en) begin
                    bits_q[upd_set][0] <= ~upd_way[1];
                    if (upd_way[1]) begin
                        bits_q[upd_set][2] <= ~upd_way[0];
                    end else begin
                        bits_q[upd_set][1] <= ~upd_way[0];
                    end
                end
            end

            assign rd      = bits_q[vic_set];
            assign vic_way = rd[0] ? {1'b1, rd[2]} : {1'b0, rd[1]};
        end
    endgenerate

endmodule

// File: rtl/cache_mem_assoc.sv
// N-way set-associative cache storage: registered lookup with write-hit update, PLRU line fills.
// Latency: lookup response one cycle after accept; fill_done one cycle after the last fill word.
// Backpressure: req_ready drops while filling, on fill_start or on flush (flush > fill_start > req).
//
// Ports: req_* lookup/write in, rsp_* result out; fill_* line-fill path; victim_* eviction info
// registered at fill_start; flush invalidates everything. Optional macro CACHE_DIRTY_TRACK_EN
// adds per-line dirty bits; without it victim_dirty is tied low (write-through use).
module cache_mem_assoc
    import cache_pkg::*;
#(
    parameter int ADDR_W = CACHE_ADDR_W,
    parameter int DATA_W = CACHE_DATA_W,
    parameter int SETS   = CACHE_SETS,
    parameter int WAYS   = CACHE_WAYS,
    parameter int WPL    = CACHE_WPL
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic                                          req_we,
    input  logic [ADDR_W-1:0]                             req_addr,
    input  logic [DATA_W-1:0]                             req_wdata,
    output logic                                          rsp_valid,
    output logic                                          rsp_hit,
    output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]    rsp_way,
    output logic [DATA_W-1:0]                             rsp_rdata,
    input  logic                                          fill_start,
    input  logic [ADDR_W-1:0]                             fill_addr,
    input  logic                                          fill_wvalid,
    input  logic [DATA_W-1:0]                             fill_wdata,
    output logic                                          fill_busy,
    output logic                                          fill_done,
    output logic                                          victim_valid,
    output logic [ADDR_W-$clog2(SETS)-$clog2(WPL)-1:0]    victim_tag,
    output logic                                          victim_dirty,
    input  logic                                          flush
);

    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(WPL);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t             state_q;
    logic [OFF_W-1:0]   cnt_q;
    logic [WAY_W-1:0]   fill_way_q;
    logic [IDX_W-1:0]   fill_set_q;
    logic [TAG_W-1:0]   fill_tag_q;
    logic [WAYS-1:0]    valid_q [SETS];
    logic [TAG_W-1:0]   tag_mem [WAYS][SETS];
    logic [DATA_W-1:0]  data_mem [WAYS][SETS*WPL];

    logic [IDX_W-1:0]   req_idx, fill_idx;
    logic [OFF_W-1:0]   req_off;
    logic [TAG_W-1:0]   req_tag, fill_tag;
    logic               hit_any, inv_any;
    logic [WAY_W-1:0]   hit_way, inv_way, vic_way, plru_vic;
    logic [DATA_W-1:0]  hit_data;
    logic               in_idle, acc, wr_hit, fill_go, fill_wr, fill_last, plru_upd;

    assign req_idx  = IDX_W'(addr_index(32'(req_addr), OFF_W, IDX_W));
    assign req_off  = OFF_W'(addr_offset(32'(req_addr), OFF_W));
    assign req_tag  = TAG_W'(addr_tag(32'(req_addr), OFF_W, IDX_W));
    assign fill_idx = IDX_W'(addr_index(32'(fill_addr), OFF_W, IDX_W));
    assign fill_tag = TAG_W'(addr_tag(32'(fill_addr), OFF_W, IDX_W));

    // Descending scan so the lowest matching / invalid way is the one left selected.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_mem[w][req_idx] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[fill_idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        hit_data = data_mem[hit_way][{req_idx, req_off}];
        vic_way  = inv_any ? inv_way : plru_vic;
    end

    assign in_idle   = (state_q == IDLE);
    assign fill_busy = !in_idle;
    assign req_ready = reset && in_idle && !fill_start && !flush;
    assign acc       = req_valid && req_ready;
    assign wr_hit    = acc && req_we && hit_any;
    assign fill_go   = in_idle && fill_start && !flush;
    assign fill_wr   = !in_idle && fill_wvalid && !flush;
    assign fill_last = fill_wr && (cnt_q == OFF_W'(WPL - 1));
    assign plru_upd  = (acc && hit_any) || fill_last;

    plru_tree #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_plru (
        .clk     (clk),
        .reset   (reset),
        .clr     (flush),
        .upd_en  (plru_upd),
        .upd_set (fill_last ? fill_set_q : req_idx),
        .upd_way (fill_last ? fill_way_q : hit_way),
        .vic_set (fill_idx),
        .vic_way (plru_vic)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            fill_way_q   <= '0;
            fill_set_q   <= '0;
            fill_tag_q   <= '0;
            valid_q      <= '{default: '0};
            rsp_valid    <= 1'b0;
            rsp_hit      <= 1'b0;
            rsp_way      <= '0;
            rsp_rdata    <= '0;
            fill_done    <= 1'b0;
            victim_valid <= 1'b0;
            victim_tag   <= '0;
        end else begin
            rsp_valid <= acc;
            fill_done <= fill_last;
            if (acc) begin
                rsp_hit   <= hit_any;
                rsp_way   <= hit_way;
                rsp_rdata <= hit_any ? hit_data : '0;
            end
            if (flush) begin
                // Aborts any fill in progress; the partial line never becomes valid.
                state_q <= IDLE;
                cnt_q   <= '0;
                valid_q <= '{default: '0};
            end else begin
                case (state_q)
                    IDLE: begin
                        if (fill_start) begin
                            state_q      <= FILL;
                            cnt_q        <= '0;
                            fill_way_q   <= vic_way;
                            fill_set_q   <= fill_idx;
                            fill_tag_q   <= fill_tag;
                            victim_valid <= valid_q[fill_idx][vic_way];
                            victim_tag   <= valid_q[fill_idx][vic_way] ?
                                            tag_mem[vic_way][fill_idx] : '0;
                            // Old line is overwritten word by word, so drop it now.
                            valid_q[fill_idx][vic_way] <= 1'b0;
                        end
                    end
                    FILL: begin
                        if (fill_wvalid) begin
                            cnt_q <= cnt_q + OFF_W'(1);
                            if (fill_last) begin
                                state_q <= IDLE;
                                valid_q[fill_set_q][fill_way_q] <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            data_mem[hit_way][{req_idx, req_off}] <= req_wdata;
        end
        if (fill_wr) begin
            data_mem[fill_way_q][{fill_set_q, cnt_q}] <= fill_wdata;
        end
        if (fill_last) begin
            tag_mem[fill_way_q][fill_set_q] <= fill_tag_q;
        end
    end

`ifdef CACHE_DIRTY_TRACK_EN
    logic [WAYS-1:0] dirty_q [SETS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dirty_q      <= '{default: '0};
            victim_dirty <= 1'b0;
        end else if (flush) begin
            dirty_q <= '{default: '0};
        end else begin
            if (wr_hit) begin
                dirty_q[req_idx][hit_way] <= 1'b1;
            end
            if (fill_last) begin
                dirty_q[fill_set_q][fill_way_q] <= 1'b0;
            end
            if (fill_go) begin
                victim_dirty <= valid_q[fill_idx][vic_way] && dirty_q[fill_idx][vic_way];
            end
        end
    end
`else
    assign victim_dirty = 1'b0;
`endif

endmodule

// File: tb/tb_cache_mem_assoc.sv
// Scoreboard bench for cache_mem_assoc (default parameters: 2 ways, 16 sets, 4 words per line).
// Lookup expectations come from a plain array/LRU model and are popped by a response monitor.
// Fill, victim, flush, priority and reset-mid-fill behaviour are checked inline.
module tb_cache_mem_assoc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [0:0]  rsp_way;
    logic [31:0] rsp_rdata;
    logic        fill_start = 1'b0;
    logic [9:0]  fill_addr = '0;
    logic        fill_wvalid = 1'b0;
    logic [31:0] fill_wdata = '0;
    logic        fill_busy;
    logic        fill_done;
    logic        victim_valid;
    logic [3:0]  victim_tag;
    logic        victim_dirty;
    logic        flush = 1'b0;

    always #5 clk = ~clk;

    cache_mem_assoc dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_hit      (rsp_hit),
        .rsp_way      (rsp_way),
        .rsp_rdata    (rsp_rdata),
        .fill_start   (fill_start),
        .fill_addr    (fill_addr),
        .fill_wvalid  (fill_wvalid),
        .fill_wdata   (fill_wdata),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .victim_valid (victim_valid),
        .victim_tag   (victim_tag),
        .victim_dirty (victim_dirty),
        .flush        (flush)
    );

    typedef struct {
        bit          hit;
        int          way;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    // Reference model: 2 ways x 16 sets, true LRU (equivalent to tree PLRU at 2 ways).
    bit          mv[2][16];
    int          mt[2][16];
    logic [31:0] md[2][16][4];
    bit          mdirty[2][16];
    int          mlru[16];   // way to evict when both ways are valid

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 16; s++) begin
                mv[w][s]     = 1'b0;
                mdirty[w][s] = 1'b0;
            end
        end
        for (int s = 0; s < 16; s++) mlru[s] = 0;
    endtask

    // Response monitor: every rsp_valid must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (rsp_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response t=%0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (rsp_hit !== mon_e.hit ||
                    (mon_e.hit && (rsp_way !== 1'(mon_e.way) || rsp_rdata !== mon_e.rdata))) begin
                    bad++;
                    $display("FAIL rsp: got hit=%0d way=%0d rdata=%0h expected hit=%0d way=%0d rdata=%0h t=%0t",
                             rsp_hit, rsp_way, rsp_rdata, mon_e.hit, mon_e.way, mon_e.rdata, $time);
                end
            end
        end
    end

    task automatic do_lookup(input logic [9:0] a, input bit we, input logic [31:0] wd);
        int   s, t, o;
        exp_t e;
        s = (int'(a) >> 2) & 15;
        t = int'(a) >> 6;
        o = int'(a) & 3;
        @(negedge clk);
        req_valid   = 1'b1;
        req_we      = we;
        req_addr    = a;
        req_wdata   = wd;
        fill_wvalid = 1'($urandom_range(0, 1));   // must be ignored in IDLE
        fill_wdata  = $urandom;
        #1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        e.hit = 1'b0;
        e.way = 0;
        e.rdata = '0;
        for (int w = 1; w >= 0; w--) begin
            if (mv[w][s] && mt[w][s] == t) begin
                e.hit = 1'b1;
                e.way = w;
            end
        end
        if (e.hit) begin
            e.rdata = md[e.way][s][o];
            mlru[s] = 1 - e.way;
            if (we) begin
                md[e.way][s][o]  = wd;
                mdirty[e.way][s] = 1'b1;
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
        req_valid   = 1'b0;
        req_we      = 1'b0;
        fill_wvalid = 1'b0;
        chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    endtask

    // gap_at: word index preceded by one idle cycle (-1 none); rnd: random gaps/data;
    // abort_at: word index at which flush aborts the fill (-1 none).
    task automatic do_fill(input logic [9:0] a, input logic [31:0] base, input int gap_at,
                           input bit rnd, input int abort_at, input bit also_req);
        int          s, t, vw, et, g;
        bit          ev, ed;
        logic [31:0] w[4];
        s = (int'(a) >> 2) & 15;
        t = int'(a) >> 6;
        for (int i = 0; i < 4; i++) w[i] = rnd ? $urandom : base + 32'(i);
        @(negedge clk);
        fill_start = 1'b1;
        fill_addr  = {a[9:2], 2'($urandom_range(0, 3))};
        if (also_req) begin
            req_valid = 1'b1;
            req_addr  = 10'($urandom);
            #1;
            chk("req_ready_vs_fill_start", 32'(req_ready), 32'd0);
        end
        vw = !mv[0][s] ? 0 : (!mv[1][s] ? 1 : mlru[s]);
        ev = mv[vw][s];
        et = mt[vw][s];
`ifdef CACHE_DIRTY_TRACK_EN
        ed = ev && mdirty[vw][s];
`else
        ed = 1'b0;
`endif
        @(negedge clk);
        fill_start = 1'b0;
        req_valid  = 1'b0;
        chk("fill_busy_start", 32'(fill_busy), 32'd1);
        chk("victim_valid", 32'(victim_valid), 32'(ev));
        if (ev) chk("victim_tag", 32'(victim_tag), 32'(et));
        chk("victim_dirty", 32'(victim_dirty), 32'(ed));
        if (also_req) chk("rsp_valid_suppressed", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == abort_at) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                chk("fill_busy_abort", 32'(fill_busy), 32'd0);
                chk("fill_done_abort", 32'(fill_done), 32'd0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("fill_done_after_abort", 32'(fill_done), 32'd0);
                end
                model_clear();
                return;
            end
            g = rnd ? $urandom_range(0, 2) : ((i == gap_at) ? 1 : 0);
            for (int k = 0; k < g; k++) begin
                fill_start = 1'($urandom_range(0, 1));   // ignored while filling
                @(negedge clk);
            end
            fill_start  = 1'b0;
            fill_wvalid = 1'b1;
            fill_wdata  = w[i];
            @(negedge clk);
            fill_wvalid = 1'b0;
        end
        chk("fill_done_pulse", 32'(fill_done), 32'd1);
        chk("fill_busy_end", 32'(fill_busy), 32'd0);
        @(negedge clk);
        chk("fill_done_single", 32'(fill_done), 32'd0);
        mv[vw][s]     = 1'b1;
        mt[vw][s]     = t;
        mdirty[vw][s] = 1'b0;
        mlru[s]       = 1 - vw;
        for (int i = 0; i < 4; i++) md[vw][s][i] = w[i];
    endtask

    task automatic do_flush(input bit with_other);
        @(negedge clk);
        flush = 1'b1;
        if (with_other) begin
            req_valid  = 1'b1;
            req_addr   = 10'($urandom);
            fill_start = 1'b1;
            #1;
            chk("req_ready_vs_flush", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        flush      = 1'b0;
        req_valid  = 1'b0;
        fill_start = 1'b0;
        chk("fill_busy_after_flush", 32'(fill_busy), 32'd0);
        model_clear();
    endtask

    task automatic do_reset_mid_fill(input logic [9:0] a);
        @(negedge clk);
        fill_start = 1'b1;
        fill_addr  = a;
        @(negedge clk);
        fill_start  = 1'b0;
        fill_wvalid = 1'b1;
        fill_wdata  = $urandom;
        @(negedge clk);
        fill_wvalid = 1'b0;
        reset = 1'b0;
        #1;
        chk("fill_busy_async_reset", 32'(fill_busy), 32'd0);
        chk("victim_valid_async_reset", 32'(victim_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] ra;
        int         r;
        model_clear();
        repeat (2) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_fill_busy", 32'(fill_busy), 32'd0);
        chk("reset_fill_done", 32'(fill_done), 32'd0);
        chk("reset_victim_valid", 32'(victim_valid), 32'd0);
        chk("reset_victim_dirty", 32'(victim_dirty), 32'd0);
        reset = 1'b1;
        #1;
        chk("req_ready_after_reset", 32'(req_ready), 32'd1);

        // Cold miss, fill with one idle gap, then hit on word 2.
        do_lookup(10'h3A4, 1'b0, '0);
        do_fill(10'h3A4, 32'hA0, 2, 1'b0, -1, 1'b0);
        do_lookup(10'h3A6, 1'b0, '0);

        // Replacement in set 9: tags 1, 2, read 1, then 3 evicts 2.
        do_fill(10'h064, 32'h100, -1, 1'b0, -1, 1'b0);
        do_fill(10'h0A4, 32'h200, -1, 1'b0, -1, 1'b0);
        do_lookup(10'h064, 1'b0, '0);
        do_fill(10'h0E4, 32'h300, -1, 1'b0, -1, 1'b0);
        chk("plan_victim_valid", 32'(victim_valid), 32'd1);
        chk("plan_victim_tag", 32'(victim_tag), 32'd2);
        do_lookup(10'h064, 1'b0, '0);
        do_lookup(10'h0A4, 1'b0, '0);

        // Write hit returns old data, then new data; evicting it reports dirty when tracked.
        do_lookup(10'h065, 1'b1, 32'h55);
        do_lookup(10'h065, 1'b0, '0);
        do_lookup(10'h0E4, 1'b0, '0);
        do_fill(10'h124, 32'h400, -1, 1'b0, -1, 1'b0);
        chk("plan_evict_tag", 32'(victim_tag), 32'd1);
`ifdef CACHE_DIRTY_TRACK_EN
        chk("plan_evict_dirty", 32'(victim_dirty), 32'd1);
`else
        chk("plan_evict_dirty", 32'(victim_dirty), 32'd0);
`endif

        // Flush after two of four words: no fill_done, everything misses.
        do_fill(10'h200, 32'h500, -1, 1'b0, 2, 1'b0);
        do_lookup(10'h124, 1'b0, '0);
        do_lookup(10'h065, 1'b0, '0);
        do_lookup(10'h200, 1'b0, '0);

        // fill_start beats a simultaneous request.
        do_fill(10'h300, 32'h600, -1, 1'b0, -1, 1'b1);
        do_lookup(10'h301, 1'b0, '0);
        do_flush(1'b1);
        do_lookup(10'h301, 1'b0, '0);

        // Reset in the middle of a fill leaves nothing valid.
        do_fill(10'h3A4, 32'h700, -1, 1'b0, -1, 1'b0);
        do_reset_mid_fill(10'h3A4);
        do_lookup(10'h3A4, 1'b0, '0);

        // Random traffic over a small address window so hits and evictions are frequent.
        for (int n = 0; n < 400; n++) begin
            ra = 10'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            r  = $urandom_range(0, 99);
            if (r < 55)      do_lookup(ra, 1'b0, '0);
            else if (r < 75) do_lookup(ra, 1'b1, $urandom);
            else if (r < 95) do_fill(ra, '0, -1, 1'b1, -1, 1'($urandom_range(0, 1)));
            else if (r < 97) do_fill(ra, '0, -1, 1'b1, $urandom_range(0, 3), 1'b0);
            else             do_flush(1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
